lcu_cmp_pipe: RTL and testbench



---
 rtl/lcu_cmp_pipe.sv | 167 ++++++++++++++++
 tb/tb_lcu_cmp_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcu_cmp_pipe.sv
// Streaming wide comparator: per-slice equal/greater pairs merged by a
// registered RADIX-ary lookahead tree, with valid/ready flow control.
module lcu_cmp_pipe #(
    parameter int WIDTH     = 32,
    parameter int CHUNK     = 4,
    parameter int RADIX     = 2,
    parameter int TAG_WIDTH = 1
) (
    input  logic                 CLK,
    input  logic                 ARST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 SIGNED,
    input  logic [2:0]           MODE,
    input  logic [TAG_WIDTH-1:0] TAG_IN,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 Y,
    output logic [TAG_WIDTH-1:0] TAG_OUT
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;

    function automatic int cnt_at(input int lvl);
        int n;
        n = NCHUNK;
        for (int i = 0; i < lvl; i++) n = (n + RADIX - 1) / RADIX;
        return n;
    endfunction

    function automatic int num_levels();
        int n;
        int l;
        n = NCHUNK;
        l = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (n > 1) begin
                n = (n + RADIX - 1) / RADIX;
                l++;
            end
        end
        return l;
    endfunction

    localparam int L = num_levels();

    logic en;
    assign en       = ~OUT_VALID | OUT_READY;
    assign IN_READY = en;

    // Biasing the sign bit turns a two's-complement compare into an unsigned one
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] a_x;
    logic [WIDTH-1:0] b_x;

    always_comb begin
        flip            = '0;
        flip[WIDTH-1]   = SIGNED;
    end

    assign a_x = A ^ flip;
    assign b_x = B ^ flip;

    logic [NCHUNK-1:0] p0_d;
    logic [NCHUNK-1:0] g0_d;

    for (genvar k = 0; k < NCHUNK; k++) begin : slice
        localparam int LO = k * CHUNK;
        localparam int W  = (LO + CHUNK > WIDTH) ? WIDTH - LO : CHUNK;
        assign p0_d[k] = (a_x[LO +: W] == b_x[LO +: W]);
        assign g0_d[k] = (a_x[LO +: W] >  b_x[LO +: W]);
    end

    logic [L:0]           vld_q;
    logic [2:0]           mode_q [L+1];
    logic [TAG_WIDTH-1:0] tag_q  [L+1];

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            vld_q <= '0;
            for (int i = 0; i <= L; i++) begin
                mode_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (en) begin
            vld_q[0] <= IN_VALID;
            if (IN_VALID) begin
                mode_q[0] <= MODE;
                tag_q[0]  <= TAG_IN;
            end
            for (int i = 1; i <= L; i++) begin
                vld_q[i]  <= vld_q[i-1];
                mode_q[i] <= mode_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    for (genvar l = 0; l <= L; l++) begin : lvl
        localparam int N = cnt_at(l);
        logic [N-1:0] p_d;
        logic [N-1:0] g_d;
        logic [N-1:0] p_q;
        logic [N-1:0] g_q;

        if (l == 0) begin : leaf
            assign p_d = p0_d;
            assign g_d = g0_d;
        end else begin : merge
            localparam int NP = cnt_at(l - 1);
            for (genvar j = 0; j < N; j++) begin : grp
                localparam int BASE = j * RADIX;
                localparam int GS   = (NP - BASE < RADIX) ? NP - BASE : RADIX;
                logic gg;
                logic pp;
                // Fold from the most significant member downwards
                always_comb begin
                    gg = lvl[l-1].g_q[BASE+GS-1];
                    pp = lvl[l-1].p_q[BASE+GS-1];
                    for (int m = GS - 2; m >= 0; m--) begin
                        gg = gg | (pp & lvl[l-1].g_q[BASE+m]);
                        pp = pp & lvl[l-1].p_q[BASE+m];
                    end
                end
                assign g_d[j] = gg;
                assign p_d[j] = pp;
            end
        end

        always_ff @(posedge CLK or posedge ARST) begin
            if (ARST) begin
                p_q <= '0;
                g_q <= '0;
            end else if (en && (l != 0 || IN_VALID)) begin
                p_q <= p_d;
                g_q <= g_d;
            end
        end
    end

    logic p_o;
    logic g_o;
    logic res;

    assign p_o = lvl[L].p_q[0];
    assign g_o = lvl[L].g_q[0];

    always_comb begin
        res = 1'b0;
        case (mode_q[L])
            3'd0:    res = ~g_o & ~p_o;
            3'd1:    res = ~g_o;
            3'd2:    res = g_o;
            3'd3:    res = g_o | p_o;
            3'd4:    res = p_o;
            3'd5:    res = ~p_o;
            default: res = 1'b0;
        endcase
    end

    assign OUT_VALID = vld_q[L];
    assign Y         = vld_q[L] & res;
    assign TAG_OUT   = tag_q[L];

endmodule

// File: tb/tb_lcu_cmp_pipe.sv
// Directed and randomised checks of lcu_cmp_pipe at 16/4/2 and 13/4/3.
module tb_lcu_cmp_pipe;

    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    logic        iv, ir, ov, orr, y, sg;
    logic [15:0] a, b;
    logic [2:0]  md;
    logic [7:0]  tg, to;

    logic        iv2, ir2, ov2, or2, y2, sg2;
    logic [12:0] a2, b2;
    logic [2:0]  md2;
    logic [3:0]  tg2, to2;

    int checks = 0;
    int failures = 0;

    lcu_cmp_pipe #(.WIDTH(16), .CHUNK(4), .RADIX(2), .TAG_WIDTH(8)) d16 (
        .CLK(clk), .ARST(arst), .IN_VALID(iv), .IN_READY(ir),
        .A(a), .B(b), .SIGNED(sg), .MODE(md), .TAG_IN(tg),
        .OUT_VALID(ov), .OUT_READY(orr), .Y(y), .TAG_OUT(to)
    );

    lcu_cmp_pipe #(.WIDTH(13), .CHUNK(4), .RADIX(3), .TAG_WIDTH(4)) d13 (
        .CLK(clk), .ARST(arst), .IN_VALID(iv2), .IN_READY(ir2),
        .A(a2), .B(b2), .SIGNED(sg2), .MODE(md2), .TAG_IN(tg2),
        .OUT_VALID(ov2), .OUT_READY(or2), .Y(y2), .TAG_OUT(to2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ref_cmp(input logic [15:0] ra, input logic [15:0] rb,
                                   input bit rs, input logic [2:0] rm);
        longint av;
        longint bv;
        av = longint'(ra);
        bv = longint'(rb);
        if (rs && ra[15]) av = av - 65536;
        if (rs && rb[15]) bv = bv - 65536;
        case (rm)
            3'd0: return av < bv;
            3'd1: return av <= bv;
            3'd2: return av > bv;
            3'd3: return av >= bv;
            3'd4: return av == bv;
            3'd5: return av != bv;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drain();
        iv = 0; orr = 1; iv2 = 0; or2 = 1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL reset_ov got=%0b exp=0", ov); end
        checks++; if (y !== 1'b0) begin failures++; $display("FAIL reset_y got=%0b exp=0", y); end
        checks++; if (to !== 8'h00) begin failures++; $display("FAIL reset_tag got=%0h exp=0", to); end
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL reset_ir got=%0b exp=1", ir); end
        @(negedge clk);
        arst = 0;
        tick();
    endtask

    task automatic lat16(input string nm, input logic [15:0] va, input logic [15:0] vb,
                         input bit vs, input logic [2:0] vm, input bit ey);
        iv = 1; a = va; b = vb; sg = vs; md = vm; tg = 8'hA5; orr = 1;
        tick();
        iv = 0;
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL %s_c1 ov got=%0b exp=0", nm, ov); end
        tick();
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL %s_c2 ov got=%0b exp=0", nm, ov); end
        tick();
        checks++; if (ov !== 1'b1) begin failures++; $display("FAIL %s_c3 ov got=%0b exp=1", nm, ov); end
        checks++; if (y !== ey) begin failures++; $display("FAIL %s_y got=%0b exp=%0b", nm, y, ey); end
        checks++; if (to !== 8'hA5) begin failures++; $display("FAIL %s_tag got=%0h exp=a5", nm, to); end
        tick();
    endtask

    task automatic lat13(input string nm, input logic [12:0] va, input logic [12:0] vb,
                         input logic [2:0] vm, input bit ey);
        iv2 = 1; a2 = va; b2 = vb; sg2 = 0; md2 = vm; tg2 = 4'h9; or2 = 1;
        tick();
        iv2 = 0;
        tick();
        checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL %s_c2 ov got=%0b exp=0", nm, ov2); end
        tick();
        checks++; if (ov2 !== 1'b1) begin failures++; $display("FAIL %s_c3 ov got=%0b exp=1", nm, ov2); end
        checks++; if (y2 !== ey) begin failures++; $display("FAIL %s_y got=%0b exp=%0b", nm, y2, ey); end
        checks++; if (to2 !== 4'h9) begin failures++; $display("FAIL %s_tag got=%0h exp=9", nm, to2); end
        tick();
    endtask

    task automatic test_mode_sweep();
        int ey[8] = '{0, 1, 0, 1, 1, 0, 0, 0};
        orr = 1; a = 16'h1234; b = 16'h1234; sg = 0;
        for (int c = 0; c < 12; c++) begin
            iv = (c < 8);
            md = 3'(c);
            tg = 8'(c);
            #1;
            if (c >= 3 && c < 11) begin
                checks++; if (ov !== 1'b1) begin failures++; $display("FAIL sweep_ov%0d got=%0b exp=1", c - 3, ov); end
                checks++; if (y !== 1'(ey[c-3])) begin failures++; $display("FAIL sweep_y%0d got=%0b exp=%0d", c - 3, y, ey[c-3]); end
                checks++; if (to !== 8'(c - 3)) begin failures++; $display("FAIL sweep_tag%0d got=%0h exp=%0h", c - 3, to, c - 3); end
            end
            tick();
        end
        iv = 0;
    endtask

    task automatic test_stall();
        logic [15:0] va[4] = '{16'h0001, 16'hFFFF, 16'h0005, 16'h00F0};
        logic [15:0] vb[4] = '{16'h0002, 16'h0001, 16'h0005, 16'h000F};
        bit          vs[4] = '{0, 1, 0, 0};
        logic [2:0]  vm[4] = '{3'd0, 3'd0, 3'd5, 3'd3};
        bit          ey[4] = '{1, 1, 0, 1};
        int s = 0, r = 0, sc = 0, cyc = 0;
        bit seen = 0;
        logic       sy;
        logic [7:0] st;
        sy = 0; st = 0;
        while (r < 4 && cyc < 40) begin
            iv = (s < 4);
            if (s < 4) begin
                a = va[s]; b = vb[s]; sg = vs[s]; md = vm[s]; tg = 8'(10 + s);
            end
            if (ov && !seen) begin
                seen = 1; sy = y; st = to;
            end
            orr = !(seen && sc < 5);
            #1;
            if (!orr) begin
                checks++; if (ir !== 1'b0) begin failures++; $display("FAIL stall_ir%0d got=%0b exp=0", sc, ir); end
                checks++; if (ov !== 1'b1) begin failures++; $display("FAIL stall_ov%0d got=%0b exp=1", sc, ov); end
                if (sc > 0) begin
                    checks++; if ({y, to} !== {sy, st}) begin failures++; $display("FAIL stall_hold%0d got=%0h exp=%0h", sc, {y, to}, {sy, st}); end
                end
                sc++;
            end else if (ov) begin
                checks++; if (y !== ey[r] || to !== 8'(10 + r)) begin
                    failures++; $display("FAIL stall_out%0d got=%0b/%0h exp=%0b/%0h", r, y, to, ey[r], 10 + r);
                end
                r++;
            end
            if (iv && ir) s++;
            tick();
            cyc++;
        end
        iv = 0; orr = 1;
        checks++; if (r != 4) begin failures++; $display("FAIL stall_count got=%0d exp=4", r); end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ov !== 1'b0) begin failures++; $display("FAIL stall_dup%0d ov got=%0b exp=0", i, ov); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        bit leak = 0;
        orr = 1; a = 16'h8000; b = 16'h7FFF; sg = 0; md = 3'd2;
        for (int c = 0; c < 3; c++) begin
            iv = 1; tg = 8'(20 + c);
            tick();
        end
        iv = 0; orr = 0;
        #1;
        checks++; if (ov !== 1'b1 || y !== 1'b1) begin failures++; $display("FAIL rst_pre got=%0b/%0b exp=1/1", ov, y); end
        #2;
        arst = 1;
        #1;
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL rst_ov got=%0b exp=0", ov); end
        checks++; if (y !== 1'b0) begin failures++; $display("FAIL rst_y got=%0b exp=0", y); end
        checks++; if (to !== 8'h00) begin failures++; $display("FAIL rst_tag got=%0h exp=0", to); end
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL rst_ir got=%0b exp=1", ir); end
        @(negedge clk);
        arst = 0;
        orr = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ov) leak = 1;
        end
        checks++; if (leak) begin failures++; $display("FAIL rst_leak got=1 exp=0"); end
    endtask

    task automatic test_random();
        bit          qy[$];
        logic [7:0]  qt[$];
        int sent = 0, got = 0, cyc = 0;
        bit pend = 0;
        bit ey;
        logic [7:0] et;
        while (got < 10000 && cyc < 60000) begin
            if (!pend && sent < 10000 && $urandom_range(0, 3) != 0) begin
                pend = 1;
                a = 16'($urandom); b = 16'($urandom);
                if ($urandom_range(0, 3) == 0) b = a;
                sg = 1'($urandom); md = 3'($urandom_range(0, 7)); tg = 8'(sent);
            end
            iv = pend;
            if (!pend) begin a = 'x; b = 'x; end
            orr = ($urandom_range(0, 3) != 0);
            #1;
            if (ov && orr) begin
                if (qy.size() == 0) begin
                    checks++; failures++; $display("FAIL rand_extra tag got=%0h exp=none", to);
                end else begin
                    ey = qy.pop_front();
                    et = qt.pop_front();
                    checks++; if (y !== ey || to !== et) begin
                        failures++; $display("FAIL rand_%0d got=%0b/%0h exp=%0b/%0h", got, y, to, ey, et);
                    end
                end
                got++;
            end
            if (iv && ir) begin
                qy.push_back(ref_cmp(a, b, sg, md));
                qt.push_back(tg);
                sent++;
                pend = 0;
            end
            tick();
            cyc++;
        end
        iv = 0;
        checks++; if (got != 10000) begin failures++; $display("FAIL rand_count got=%0d exp=10000", got); end
    endtask

    initial begin
        iv = 0; orr = 1; a = 0; b = 0; sg = 0; md = 0; tg = 0;
        iv2 = 0; or2 = 1; a2 = 0; b2 = 0; sg2 = 0; md2 = 0; tg2 = 0;
        test_reset();
        lat16("gt_uns", 16'h8000, 16'h7FFF, 0, 3'd2, 1);
        lat16("gt_sgn", 16'h8000, 16'h7FFF, 1, 3'd2, 0);
        lat16("lt_sgn", 16'hFFFF, 16'h0001, 1, 3'd0, 1);
        lat16("lt_uns", 16'hFFFF, 16'h0001, 0, 3'd0, 0);
        lat13("p13_ge", 13'h1000, 13'h0FFF, 3'd3, 1);
        lat13("p13_lt", 13'h0FFF, 13'h1000, 3'd3, 0);
        drain();
        test_mode_sweep();
        drain();
        test_stall();
        drain();
        test_async_reset();
        drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
